// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants for the data-memory load/store unit
package lsu_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // FSM state encoding
    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t IDLE = 2'd0;
    localparam lsu_state_t WAIT = 2'd1;
    localparam lsu_state_t RESP = 2'd2;

    // Response codes
    localparam logic [1:0] RC_OK       = 2'b00;
    localparam logic [1:0] RC_MISALIGN = 2'b01;
    localparam logic [1:0] RC_RANGE    = 2'b10;
    localparam logic [1:0] RC_ILLEGAL  = 2'b11;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering, load extension and funct3/alignment checks
module lsu_align
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned,
    output logic        illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Little-endian lane extraction from the addressed word
    assign byte_sel = rword[{addr_lo, 3'b000} +: 8];
    assign half_sel = rword[{addr_lo[1], 4'b0000} +: 16];

    // Decode access size into lane enables, replicated store data and extended load data
    always_comb begin
        be         = 4'b0000;
        wdata_lane = 32'h0;
        rdata_ext  = 32'h0;
        misaligned = 1'b0;
        if (we) begin
            illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        end else begin
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        case (funct3)
            F3_B, F3_BU: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = (funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel}
                                              : {24'h0, byte_sel};
            end
            F3_H, F3_HU: begin
                misaligned = addr_lo[0];
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = (funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel}
                                              : {16'h0, half_sel};
            end
            F3_W: begin
                misaligned = (addr_lo != 2'b00);
                be         = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - byte-laned data memory with sub-word load/store and latency handshake
module dmem_lsu #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h10010000,
    parameter int          READ_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  rsp_code
);
    import lsu_pkg::*;

    localparam int          IW   = $clog2(DEPTH_WORDS);
    localparam int          AW   = IW + 2;
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    logic [31:0] mem [DEPTH_WORDS];

    lsu_state_t  state;
    logic [1:0]  cnt;
    logic [31:0] rdata_q;
    logic [1:0]  code_q;

    logic [31:0] offset;
    logic [IW-1:0] idx;
    logic        out_of_range;
    logic [31:0] rword;
    logic [3:0]  be;
    logic [31:0] wdata_lane;
    logic [31:0] rdata_ext;
    logic        misaligned;
    logic        illegal;
    logic        fault;
    logic [1:0]  code;
    logic        accept;

    // Offset wraps to a huge value below BASE_ADDR, so one compare covers both range ends
    assign offset       = req_addr - BASE_ADDR;
    assign out_of_range = ({1'b0, offset} >= SPAN);
    assign idx          = offset[AW-1:2];
    assign rword        = mem[idx];

    lsu_align u_align (
        .we         (req_we),
        .funct3     (req_funct3),
        .addr_lo    (req_addr[1:0]),
        .wdata      (req_wdata),
        .rword      (rword),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    assign fault  = illegal | misaligned | out_of_range;
    assign code   = illegal      ? RC_ILLEGAL  :
                    misaligned   ? RC_MISALIGN :
                    out_of_range ? RC_RANGE    : RC_OK;
    assign accept = (state == IDLE) && req_valid && !rst;

    // Store: write enabled byte lanes at the acceptance edge; array is never reset
    always_ff @(posedge clk) begin
        if (accept && req_we && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata_lane[8*i +: 8];
                end
            end
        end
    end

    // Handshake FSM; the load result is captured at acceptance and held until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            rdata_q <= 32'h0;
            code_q  <= RC_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rdata_q <= (fault || req_we) ? 32'h0 : rdata_ext;
                        code_q  <= code;
                        if (READ_LAT == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= 2'(READ_LAT - 1);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
    assign rsp_code  = rsp_valid ? code_q : RC_OK;
    assign rsp_err   = rsp_valid && (code_q != RC_OK);

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - self-checking bench for dmem_lsu at read latencies 1 and 3
module tb_dmem_lsu;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h10010000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_err    [2];
    logic [1:0]  rsp_code   [2];

    int total = 0;
    int bad   = 0;
    int lat [2] = '{1, 3};
    logic [7:0] mb [2][4*DEPTH];

    dmem_lsu #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .READ_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .rsp_code(rsp_code[0])
    );

    dmem_lsu #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .READ_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .rsp_code(rsp_code[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: byte-array memory, RV32I size/sign rules, fault priority
    task automatic model_access(input int d, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] erd, output logic [1:0] ecode);
        int n;
        longint off;
        logic [31:0] v;
        erd   = 32'h0;
        ecode = 2'd0;
        n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off   = longint'(addr) - longint'(BASE);
        if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) ecode = 2'd3;
        else if (addr % n != 0) ecode = 2'd1;
        else if (off < 0 || off >= 4*DEPTH) ecode = 2'd2;
        else if (we) begin
            for (int i = 0; i < n; i++) begin
                v = wdata >> (8*i);
                mb[d][int'(off) + i] = v[7:0];
            end
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(mb[d][int'(off) + i]) << (8*i));
            if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            erd = v;
        end
    endtask

    // One full transaction; entered and left at 1 time unit after a rising edge
    task automatic txn(input int d, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int hold, output logic [31:0] got);
        logic [31:0] erd;
        logic [1:0]  ecode;
        int n;
        model_access(d, we, f3, addr, wdata, erd, ecode);
        check("req_ready_idle", req_ready[d], 1);
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_funct3[d] = f3;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        n = 1;
        while (!rsp_valid[d] && n < 12) begin
            check("req_ready_wait", req_ready[d], 0);
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, lat[d]);
        check("rsp_rdata", rsp_rdata[d], erd);
        check("rsp_err", rsp_err[d], ecode != 2'd0);
        check("rsp_code", rsp_code[d], ecode);
        got = rsp_rdata[d];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", rsp_valid[d], 1);
            check("hold_rdata", rsp_rdata[d], erd);
            check("hold_code", rsp_code[d], ecode);
            check("hold_req_ready", req_ready[d], 0);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        check("done_valid", rsp_valid[d], 0);
        check("done_req_ready", req_ready[d], 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] g;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = 3'd0;
            req_addr[d] = 32'h0; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b0;
        end
        #3;
        for (int d = 0; d < 2; d++) begin
            check("reset_rsp_valid", rsp_valid[d], 0);
            check("reset_rsp_rdata", rsp_rdata[d], 0);
            check("reset_rsp_err", rsp_err[d], 0);
            check("reset_rsp_code", rsp_code[d], 0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) check("reset_req_ready", req_ready[d], 1);
        @(posedge clk); #1;

        // Known memory contents so the model and the array agree
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < DEPTH; w++) txn(d, 1'b1, 3'd2, BASE + 32'(4*w), 32'h0, 0, g);

        // Directed word, byte and halfword accesses at latency 1
        txn(0, 1'b1, 3'd2, BASE, 32'h12345678, 0, g);
        txn(0, 1'b0, 3'd2, BASE, 32'h0, 0, g);          check("plan_lw", g, 32'h12345678);
        txn(0, 1'b1, 3'd2, BASE + 4, 32'h0, 0, g);
        txn(0, 1'b1, 3'd0, BASE + 5, 32'hFFFFFFAB, 0, g);
        txn(0, 1'b0, 3'd2, BASE + 4, 32'h0, 0, g);      check("plan_lw_sb", g, 32'h0000AB00);
        txn(0, 1'b0, 3'd0, BASE + 5, 32'h0, 0, g);      check("plan_lb", g, 32'hFFFFFFAB);
        txn(0, 1'b0, 3'd4, BASE + 5, 32'h0, 0, g);      check("plan_lbu", g, 32'h000000AB);
        txn(0, 1'b1, 3'd1, BASE + 2, 32'h00008001, 0, g);
        txn(0, 1'b0, 3'd2, BASE, 32'h0, 0, g);          check("plan_lw_sh", g, 32'h80015678);
        txn(0, 1'b0, 3'd1, BASE + 2, 32'h0, 0, g);      check("plan_lh", g, 32'hFFFF8001);
        txn(0, 1'b0, 3'd5, BASE + 2, 32'h0, 0, g);      check("plan_lhu", g, 32'h00008001);

        // Faults and range boundaries
        txn(0, 1'b0, 3'd2, BASE + 2, 32'h0, 0, g);
        txn(0, 1'b1, 3'd2, BASE + 32'(4*DEPTH), 32'hDEADBEEF, 0, g);
        txn(0, 1'b1, 3'd2, BASE - 4, 32'hDEADBEEF, 0, g);
        txn(0, 1'b0, 3'd7, BASE, 32'h0, 0, g);
        txn(0, 1'b1, 3'd4, BASE, 32'hDEADBEEF, 0, g);
        txn(0, 1'b1, 3'd0, BASE + 32'(4*DEPTH - 1), 32'h000000C3, 0, g);
        txn(0, 1'b0, 3'd4, BASE + 32'(4*DEPTH - 1), 32'h0, 0, g); check("plan_top_byte", g, 32'h000000C3);
        txn(0, 1'b0, 3'd4, BASE + 32'(4*DEPTH), 32'h0, 0, g);
        txn(0, 1'b0, 3'd2, BASE, 32'h0, 0, g);          check("plan_unchanged", g, 32'h80015678);

        // Latency 3 with a held response
        txn(1, 1'b1, 3'd2, BASE + 8, 32'hCAFEBABE, 0, g);
        txn(1, 1'b0, 3'd2, BASE + 8, 32'h0, 5, g);      check("plan_lat3_lw", g, 32'hCAFEBABE);

        // Reset while a load waits
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_funct3[1] = 3'd2; req_addr[1] = BASE + 8;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        check("wait_req_ready", req_ready[1], 0);
        rst[1] = 1'b1;
        #1;
        check("rst_wait_valid", rsp_valid[1], 0);
        @(posedge clk); #1;
        rst[1] = 1'b0;
        #1;
        check("rst_wait_req_ready", req_ready[1], 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("rst_no_response", rsp_valid[1], 0);
        end

        // Reset while a response is presented must drop it before any clock edge
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("resp_presented", rsp_valid[1], 1);
        #2;
        rst[1] = 1'b1;
        #1;
        check("rst_resp_async", rsp_valid[1], 0);
        check("rst_resp_rdata", rsp_rdata[1], 0);
        @(posedge clk); #1;
        rst[1] = 1'b0;
        @(posedge clk); #1;
        check("rst_resp_stays_low", rsp_valid[1], 0);
        txn(1, 1'b0, 3'd2, BASE + 8, 32'h0, 0, g);      check("plan_after_reset", g, 32'hCAFEBABE);

        // Randomized accesses against the model, including out-of-window addresses
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 60; k++) begin
                txn(d, 1'($urandom % 2), 3'($urandom % 8),
                    BASE - 8 + $urandom_range(0, 4*DEPTH + 15), $urandom,
                    $urandom_range(0, 2), g);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Parametrised data-memory and load/store unit; replaces the fixed word-only data memory in the RV32I datapath.
- Supports RV32I sub-word loads and stores (lb/lh/lw/lbu/lhu, sb/sh/sw) through byte-lane enables and sign/zero extension.
- Provides configurable read latency, a valid/ready request/response handshake, and error reporting for misaligned, out-of-range and illegal accesses.
- Sits between the ALU address/rs2 path and the result mux; a later multicycle/pipelined core stalls on req_ready/rsp_valid.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 4.
- BASE_ADDR, 32'h10010000, byte address of word 0 (data segment); aligned to 4*DEPTH_WORDS.
- READ_LAT, 1, cycles from the acceptance edge to rsp_valid; legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 giving access size and sign.
- req_addr  in  32  byte address (ALUResult).
- req_wdata  in  32  store data (rs2); the low byte/half is used for sb/sh.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access faulted.
- rsp_code  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.

Behaviour:
- Reset (async assert, takes effect immediately, mid-transaction included):
  - state = IDLE; counter = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, rsp_code = 00.
  - req_ready = 1 once rst is low. Any in-flight response is dropped.
  - Memory array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. On req_valid: accept at that edge.
    - READ_LAT = 1 → go to RESP.
    - Otherwise → go to WAIT with counter = READ_LAT-1.
  - WAIT: req_ready = 0. Decrement counter each cycle; at 1 → RESP.
  - RESP: req_ready = 0; rsp_valid = 1. rsp_rdata, rsp_err and rsp_code are stable while rsp_ready = 0. On rsp_ready → IDLE.
- Latency: rsp_valid is first high exactly READ_LAT cycles after the acceptance edge. Minimum request spacing is READ_LAT+1 cycles.
- Request decode is combinational at acceptance and registered. Checks apply in this priority order:
  - Illegal funct3:
    - Loads: 011, 110, 111 are illegal.
    - Stores: anything other than 000, 001, 010 is illegal.
  - Misaligned: halfword with addr[0] = 1; word with addr[1:0] ≠ 0.
  - Out of range: addr < BASE_ADDR or addr ≥ BASE_ADDR + 4*DEPTH_WORDS.
- Faulted access: no memory write, rsp_rdata = 0, rsp_err = 1.
- Stores:
  - Write the enabled byte lanes at the acceptance edge. sb: lane addr[1:0]. sh: lanes {addr[1],0} and {addr[1],1}. sw: all lanes.
  - Lane data is req_wdata shifted into position.
  - Response carries rdata = 0, err = 0.
- Loads:
  - The word is read at the acceptance edge and delayed READ_LAT-1 cycles.
  - The addressed lane is extracted, then extended: lb/lh sign-extend, lbu/lhu zero-extend.
  - Little-endian.
- Ordering: the access is performed at the acceptance edge, so a load accepted after a completed store returns the stored data.
- Word index = (addr - BASE_ADDR)[log2(4*DEPTH_WORDS)-1:2]. No wrap-around: the top address + 1 is out of range.
- Request inputs are ignored outside IDLE. Holding req_valid high in IDLE issues back-to-back transactions.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state enum: IDLE, WAIT, RESP.
  - rsp_code constants: RC_OK, RC_MISALIGN, RC_RANGE, RC_ILLEGAL.
- Sub-module lsu_align is purely combinational:
  - Inputs: funct3, addr[1:0], wdata, rword.
  - Outputs: byte enable[3:0], shifted store data, extended load data, misaligned and illegal flags.
- Top level holds the FSM, latency counter, byte-laned array and range check.

Test Plan:
- READ_LAT=1: sw 0x12345678 @0x10010000, then lw @0x10010000 → rsp_rdata 0x12345678, err 0; rsp_valid one cycle after each acceptance.
- sw 0 @0x10010004; sb wdata 0xFFFFFFAB @0x10010005; then:
  - lw @0x10010004 → 0x0000AB00
  - lb @0x10010005 → 0xFFFFFFAB
  - lbu @0x10010005 → 0x000000AB
- sh 0x8001 @0x10010002 over 0x12345678 → lw returns 0x80015678; lh @0x10010002 → 0xFFFF8001; lhu → 0x00008001.
- Faults:
  - lw @0x10010002 → err 1, code 01, rdata 0.
  - sw @0x10010000+4*DEPTH_WORDS → code 10, no write.
  - load funct3 111 → code 11.
  - A subsequent lw shows memory unchanged.
- READ_LAT=3 with rsp_ready held low for 5 cycles → rsp_valid rises 3 cycles after acceptance; data stable while held; req_ready stays 0 until the cycle after rsp_ready.
- Assert rst while in WAIT → rsp_valid 0 immediately (asynchronous) and no response afterwards; after deassert, req_ready = 1 and the store made before reset is still readable.
